// File: rtl/mtm_alu_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_tx_scheduler
//  Description : Output-side scheduler for the MTM ALU link. Holds one
//                pending result frame and one pending error frame, gives the
//                error frame priority, launches one serializer frame at a
//                time, times the frame plus the idle gap, and builds the CTL
//                byte for both frame types.
//                Optional statistics counters: define TX_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_tx_scheduler #(
    parameter int DATA_FRAME_CYC = 55,
    parameter int ERR_FRAME_CYC  = 11,
    parameter int GAP_CYC        = 2
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        res_valid,
    input  logic [31:0] res_C,
    input  logic [3:0]  res_flags,
    input  logic [2:0]  res_crc,
    input  logic        err_valid,
    input  logic [5:0]  err_flags,
    output logic        ser_start,
    output logic        ser_err,
    output logic [31:0] ser_C,
    output logic [7:0]  ser_ctl,
    output logic        busy,
    output logic        res_pending,
    output logic        err_pending,
    output logic        overrun,
    input  logic        clr_overrun
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [7:0]  drop_cnt,
    output logic [15:0] data_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int MAX_LEN = (DATA_FRAME_CYC > ERR_FRAME_CYC) ? DATA_FRAME_CYC : ERR_FRAME_CYC;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] c_data_len = CNT_W'(DATA_FRAME_CYC);
    localparam logic [CNT_W-1:0] c_err_len  = CNT_W'(ERR_FRAME_CYC);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;

    // Slot contents
    logic [31:0]       r_res_C;
    logic [3:0]        r_res_flags;
    logic [2:0]        r_res_crc;
    logic [5:0]        r_err_flags;

    logic              w_may_launch;
    logic              w_launch_err;
    logic              w_launch_res;
    logic              w_launch;
    logic              w_res_accept;
    logic              w_err_accept;
    logic              w_res_drop;
    logic              w_err_drop;
    logic              w_err_par;

    // A launch can happen from IDLE, or directly out of the last GAP cycle so
    // back-to-back frames are spaced exactly 1 + frame + gap cycles apart.
    assign w_may_launch = (r_state == ST_IDLE) ||
                          ((r_state == ST_GAP) && (r_gap_cnt == '0));
    assign w_launch_err = w_may_launch && err_pending;
    assign w_launch_res = w_may_launch && !err_pending && res_pending;
    assign w_launch     = w_launch_err || w_launch_res;

    // A slot being emptied by a launch this cycle can take a new strobe.
    assign w_res_accept = res_valid && (!res_pending || w_launch_res);
    assign w_err_accept = err_valid && (!err_pending || w_launch_err);
    assign w_res_drop   = res_valid && !w_res_accept;
    assign w_err_drop   = err_valid && !w_err_accept;

    // Parity bit is 1 when {1'b1, err_flags} holds an even number of ones.
    assign w_err_par    = ~^{1'b1, r_err_flags};

    assign busy         = (r_state != ST_IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_nxt = ST_TX;
            ST_TX:   if (r_cnt == '0) w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = w_launch ? ST_TX : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame and gap timers; the launch cycle itself is the first TX cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_launch)
                r_cnt <= w_launch_err ? c_err_len : c_data_len;
            else if ((r_state == ST_TX) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;

            if ((r_state == ST_TX) && (r_cnt == '0))
                r_gap_cnt <= c_gap_last;
            else if ((r_state == ST_GAP) && (r_gap_cnt != '0))
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    // Result slot: capture on accept, free on launch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_pending <= 1'b0;
            r_res_C     <= '0;
            r_res_flags <= '0;
            r_res_crc   <= '0;
        end else if (w_res_accept) begin
            res_pending <= 1'b1;
            r_res_C     <= res_C;
            r_res_flags <= res_flags;
            r_res_crc   <= res_crc;
        end else if (w_launch_res) begin
            res_pending <= 1'b0;
        end
    end

    // Error slot: capture on accept, free on launch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pending <= 1'b0;
            r_err_flags <= '0;
        end else if (w_err_accept) begin
            err_pending <= 1'b1;
            r_err_flags <= err_flags;
        end else if (w_launch_err) begin
            err_pending <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop wins over a concurrent clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          overrun <= 1'b0;
        else if (w_res_drop || w_err_drop) overrun <= 1'b1;
        else if (clr_overrun)              overrun <= 1'b0;
    end

    // Serializer launch registers; ser_C is left untouched by error frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_start <= 1'b0;
            ser_err   <= 1'b0;
            ser_C     <= '0;
            ser_ctl   <= '0;
        end else begin
            ser_start <= w_launch;
            if (w_launch_err) begin
                ser_err <= 1'b1;
                ser_ctl <= {1'b1, r_err_flags, w_err_par};
            end else if (w_launch_res) begin
                ser_err <= 1'b0;
                ser_C   <= r_res_C;
                ser_ctl <= {1'b0, r_res_flags, r_res_crc};
            end
        end
    end

`ifdef TX_SCHED_STATS_EN
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;

    assign w_drop_inc = {1'b0, w_res_drop} + {1'b0, w_err_drop};
    assign w_drop_sum = {1'b0, drop_cnt} + {7'd0, w_drop_inc};

    // Statistics: saturating drop count, wrapping frame counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            data_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_overrun) begin
            drop_cnt <= '0;
            data_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_launch_res) data_cnt <= data_cnt + 16'd1;
            if (w_launch_err) err_cnt  <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
